// File: rtl/axi4_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_sram_responder
//  Brief    : AXI4 slave with internal word SRAM, strobed write bursts and
//             one-beat-per-cycle read bursts with OKAY/SLVERR responses.
//  Revision : 1.0  initial release
// ============================================================================
module axi4_sram_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    sys_clock,
   input  logic                    reset_rtl_n,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
   input  logic [7:0]              S_AXI_awlen,
   input  logic [2:0]              S_AXI_awsize,
   input  logic [1:0]              S_AXI_awburst,
   input  logic                    S_AXI_awvalid,
   output logic                    S_AXI_awready,
   input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
   input  logic                    S_AXI_wlast,
   input  logic                    S_AXI_wvalid,
   output logic                    S_AXI_wready,
   output logic [1:0]              S_AXI_bresp,
   output logic                    S_AXI_bvalid,
   input  logic                    S_AXI_bready,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
   input  logic [7:0]              S_AXI_arlen,
   input  logic [2:0]              S_AXI_arsize,
   input  logic [1:0]              S_AXI_arburst,
   input  logic                    S_AXI_arvalid,
   output logic                    S_AXI_arready,
   output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
   output logic [1:0]              S_AXI_rresp,
   output logic                    S_AXI_rlast,
   output logic                    S_AXI_rvalid,
   input  logic                    S_AXI_rready
);

   localparam int         c_WORD_AW     = ADDR_WIDTH - 2;
   localparam int         c_DEPTH       = 1 << c_WORD_AW;
   localparam int         c_STRB_W      = DATA_WIDTH / 8;
   localparam logic [1:0] c_BURST_FIXED = 2'b00;
   localparam logic [1:0] c_BURST_INCR  = 2'b01;
   localparam logic [2:0] c_SIZE_WORD   = 3'b010;
   localparam logic [1:0] c_RESP_OKAY   = 2'b00;
   localparam logic [1:0] c_RESP_SLVERR = 2'b10;

   localparam logic [1:0] c_W_IDLE = 2'd0;
   localparam logic [1:0] c_W_DATA = 2'd1;
   localparam logic [1:0] c_W_RESP = 2'd2;
   localparam logic       c_R_IDLE = 1'b0;
   localparam logic       c_R_DATA = 1'b1;

   logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

   // ---------------------------------------------------------------- write
   logic [1:0]           r_wstate, w_wstate_nxt;
   logic                 w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
   logic [c_WORD_AW-1:0] r_waddr;
   logic [7:0]           r_wlen, r_wcnt;
   logic                 r_wfixed, r_wok, r_werr;
   logic [1:0]           r_bresp;

   logic w_aw_hs, w_w_hs, w_b_hs, w_wbeat_last, w_aw_ok, w_werr_beat, w_wr_en;
   assign w_aw_hs      = S_AXI_awvalid && S_AXI_awready;
   assign w_w_hs       = S_AXI_wvalid && S_AXI_wready;
   assign w_b_hs       = S_AXI_bvalid && S_AXI_bready;
   assign w_wbeat_last = (r_wcnt == r_wlen);
   assign w_aw_ok      = ((S_AXI_awburst == c_BURST_INCR) || (S_AXI_awburst == c_BURST_FIXED))
                         && (S_AXI_awsize == c_SIZE_WORD);
   // wlast mismatch only flags the response; the beat count alone ends the burst
   assign w_werr_beat  = r_werr || (S_AXI_wlast != w_wbeat_last);
   assign w_wr_en      = w_w_hs && r_wok;

   always_ff @(posedge sys_clock or negedge reset_rtl_n) begin
      if (!reset_rtl_n) begin
         r_wstate      <= c_W_IDLE;
         S_AXI_awready <= 1'b0;
         S_AXI_wready  <= 1'b0;
         S_AXI_bvalid  <= 1'b0;
      end else begin
         r_wstate      <= w_wstate_nxt;
         S_AXI_awready <= w_awready_nxt;
         S_AXI_wready  <= w_wready_nxt;
         S_AXI_bvalid  <= w_bvalid_nxt;
      end
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         c_W_IDLE: if (w_aw_hs)                 w_wstate_nxt = c_W_DATA;
         c_W_DATA: if (w_w_hs && w_wbeat_last)  w_wstate_nxt = c_W_RESP;
         c_W_RESP: if (w_b_hs)                  w_wstate_nxt = c_W_IDLE;
         default:                               w_wstate_nxt = c_W_IDLE;
      endcase
   end

   always_comb begin
      w_awready_nxt = (w_wstate_nxt == c_W_IDLE);
      w_wready_nxt  = (w_wstate_nxt == c_W_DATA);
      w_bvalid_nxt  = (w_wstate_nxt == c_W_RESP);
   end

   always_ff @(posedge sys_clock or negedge reset_rtl_n) begin
      if (!reset_rtl_n) begin
         r_waddr  <= '0;
         r_wlen   <= '0;
         r_wcnt   <= '0;
         r_wfixed <= 1'b0;
         r_wok    <= 1'b0;
         r_werr   <= 1'b0;
         r_bresp  <= c_RESP_OKAY;
      end else if (w_aw_hs) begin
         r_waddr  <= S_AXI_awaddr[ADDR_WIDTH-1:2];
         r_wlen   <= S_AXI_awlen;
         r_wcnt   <= '0;
         r_wfixed <= (S_AXI_awburst == c_BURST_FIXED);
         r_wok    <= w_aw_ok;
         r_werr   <= !w_aw_ok;
      end else if (w_w_hs) begin
         r_wcnt <= r_wcnt + 8'd1;
         r_werr <= w_werr_beat;
         if (!r_wfixed)
            r_waddr <= r_waddr + 1'b1;
         if (w_wbeat_last)
            r_bresp <= w_werr_beat ? c_RESP_SLVERR : c_RESP_OKAY;
      end
   end

   assign S_AXI_bresp = r_bresp;

   always_ff @(posedge sys_clock) begin
      if (w_wr_en) begin
         for (int i = 0; i < c_STRB_W; i++) begin
            if (S_AXI_wstrb[i])
               r_mem[r_waddr][8*i +: 8] <= S_AXI_wdata[8*i +: 8];
         end
      end
   end

   // ----------------------------------------------------------------- read
   logic                 r_rstate, w_rstate_nxt;
   logic                 w_arready_nxt, w_rvalid_nxt;
   logic [c_WORD_AW-1:0] r_raddr, w_raddr_adv, w_ar_word;
   logic [7:0]           r_rlen, r_rcnt, w_rcnt_inc;
   logic                 r_rfixed, r_rok;
   logic                 w_ar_hs, w_r_hs, w_ar_ok;

   assign w_ar_hs     = S_AXI_arvalid && S_AXI_arready;
   assign w_r_hs      = S_AXI_rvalid && S_AXI_rready;
   assign w_ar_word   = S_AXI_araddr[ADDR_WIDTH-1:2];
   assign w_ar_ok     = ((S_AXI_arburst == c_BURST_INCR) || (S_AXI_arburst == c_BURST_FIXED))
                        && (S_AXI_arsize == c_SIZE_WORD);
   assign w_raddr_adv = r_rfixed ? r_raddr : r_raddr + 1'b1;
   assign w_rcnt_inc  = r_rcnt + 8'd1;

   always_ff @(posedge sys_clock or negedge reset_rtl_n) begin
      if (!reset_rtl_n) begin
         r_rstate      <= c_R_IDLE;
         S_AXI_arready <= 1'b0;
         S_AXI_rvalid  <= 1'b0;
      end else begin
         r_rstate      <= w_rstate_nxt;
         S_AXI_arready <= w_arready_nxt;
         S_AXI_rvalid  <= w_rvalid_nxt;
      end
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         c_R_IDLE: if (w_ar_hs)                w_rstate_nxt = c_R_DATA;
         c_R_DATA: if (w_r_hs && S_AXI_rlast)  w_rstate_nxt = c_R_IDLE;
         default:                              w_rstate_nxt = c_R_IDLE;
      endcase
   end

   always_comb begin
      w_arready_nxt = (w_rstate_nxt == c_R_IDLE);
      w_rvalid_nxt  = (w_rstate_nxt == c_R_DATA);
   end

   // The asynchronous read port samples pre-edge contents, giving read-before-write
   always_ff @(posedge sys_clock or negedge reset_rtl_n) begin
      if (!reset_rtl_n) begin
         r_raddr     <= '0;
         r_rlen      <= '0;
         r_rcnt      <= '0;
         r_rfixed    <= 1'b0;
         r_rok       <= 1'b0;
         S_AXI_rdata <= '0;
         S_AXI_rresp <= c_RESP_OKAY;
         S_AXI_rlast <= 1'b0;
      end else if (w_ar_hs) begin
         r_raddr     <= w_ar_word;
         r_rlen      <= S_AXI_arlen;
         r_rcnt      <= '0;
         r_rfixed    <= (S_AXI_arburst == c_BURST_FIXED);
         r_rok       <= w_ar_ok;
         S_AXI_rdata <= w_ar_ok ? r_mem[w_ar_word] : '0;
         S_AXI_rresp <= w_ar_ok ? c_RESP_OKAY : c_RESP_SLVERR;
         S_AXI_rlast <= (S_AXI_arlen == 8'd0);
      end else if (w_r_hs) begin
         if (S_AXI_rlast) begin
            S_AXI_rlast <= 1'b0;
         end else begin
            r_raddr     <= w_raddr_adv;
            r_rcnt      <= w_rcnt_inc;
            S_AXI_rdata <= r_rok ? r_mem[w_raddr_adv] : '0;
            S_AXI_rlast <= (w_rcnt_inc == r_rlen);
         end
      end
   end

   logic w_unused;
   assign w_unused = ^{S_AXI_awaddr[1:0], S_AXI_araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi4_sram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_axi4_sram_responder
//  Brief    : Directed self-checking bench for axi4_sram_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4_sram_responder;

   logic        sys_clock = 1'b0;
   logic        reset_rtl_n = 1'b0;
   logic [11:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [11:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b0;

   axi4_sram_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
      .sys_clock     (sys_clock),
      .reset_rtl_n   (reset_rtl_n),
      .S_AXI_awaddr  (awaddr),
      .S_AXI_awlen   (awlen),
      .S_AXI_awsize  (awsize),
      .S_AXI_awburst (awburst),
      .S_AXI_awvalid (awvalid),
      .S_AXI_awready (awready),
      .S_AXI_wdata   (wdata),
      .S_AXI_wstrb   (wstrb),
      .S_AXI_wlast   (wlast),
      .S_AXI_wvalid  (wvalid),
      .S_AXI_wready  (wready),
      .S_AXI_bresp   (bresp),
      .S_AXI_bvalid  (bvalid),
      .S_AXI_bready  (bready),
      .S_AXI_araddr  (araddr),
      .S_AXI_arlen   (arlen),
      .S_AXI_arsize  (arsize),
      .S_AXI_arburst (arburst),
      .S_AXI_arvalid (arvalid),
      .S_AXI_arready (arready),
      .S_AXI_rdata   (rdata),
      .S_AXI_rresp   (rresp),
      .S_AXI_rlast   (rlast),
      .S_AXI_rvalid  (rvalid),
      .S_AXI_rready  (rready)
   );

   always #5 sys_clock = ~sys_clock;

   localparam logic [1:0] c_FIXED = 2'b00;
   localparam logic [1:0] c_INCR  = 2'b01;
   localparam logic [1:0] c_WRAP  = 2'b10;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] wd [8];
   logic [3:0]  ws [8];
   logic        wl [8];
   logic [31:0] rd [8];
   logic [1:0]  rr [8];
   logic        rl [8];
   logic [31:0] bp_exp [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clock);
      #1;
   endtask

   task automatic set_beats(input int len);
      for (int i = 0; i < 8; i++) begin
         ws[i] = 4'hF;
         wl[i] = (i == len);
      end
   endtask

   task automatic aw_req(input logic [11:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
      int t = 0;
      awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      while (!awready && t < 20) begin tick(); t++; end
      check("aw_wait", 32'(t < 20), 32'd1);
      tick();
      awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
      int t = 0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      while (!wready && t < 20) begin tick(); t++; end
      check("w_wait", 32'(t < 20), 32'd1);
      tick();
      wvalid = 1'b0;
   endtask

   task automatic b_take(input logic [1:0] exp, input string tag);
      check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
      check({tag, "_bresp"}, 32'(bresp), 32'(exp));
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check({tag, "_awready"}, 32'(awready), 32'd1);
   endtask

   task automatic write_burst(input logic [11:0] a, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [1:0] exp, input string tag);
      aw_req(a, len, size, burst);
      for (int i = 0; i <= int'(len); i++) w_send(wd[i], ws[i], wl[i]);
      b_take(exp, tag);
   endtask

   task automatic wr1(input logic [11:0] a, input logic [31:0] d, input string tag);
      set_beats(0);
      wd[0] = d;
      write_burst(a, 8'd0, 3'b010, c_INCR, 2'b00, tag);
   endtask

   task automatic read_burst(input logic [11:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input string tag);
      int t = 0;
      araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      while (!arready && t < 20) begin tick(); t++; end
      check({tag, "_ar_wait"}, 32'(t < 20), 32'd1);
      tick();
      arvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
         rd[b] = rdata; rr[b] = rresp; rl[b] = rlast;
         rready = 1'b1;
         tick();
      end
      rready = 1'b0;
      check({tag, "_rvalid_end"}, 32'(rvalid), 32'd0);
      check({tag, "_arready_end"}, 32'(arready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_awready"}, 32'(awready), 32'd0);
      check({tag, "_wready"},  32'(wready),  32'd0);
      check({tag, "_bvalid"},  32'(bvalid),  32'd0);
      check({tag, "_bresp"},   32'(bresp),   32'd0);
      check({tag, "_arready"}, 32'(arready), 32'd0);
      check({tag, "_rvalid"},  32'(rvalid),  32'd0);
      check({tag, "_rlast"},   32'(rlast),   32'd0);
      check({tag, "_rresp"},   32'(rresp),   32'd0);
      check({tag, "_rdata"},   rdata,        32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset and release
      repeat (3) tick();
      check_reset_outputs("rst");
      reset_rtl_n = 1'b1;
      check("rel_awready_low", 32'(awready), 32'd0);
      tick();
      check("rel_awready", 32'(awready), 32'd1);
      check("rel_arready", 32'(arready), 32'd1);

      // Single write/read
      wr1(12'h100, 32'hDEADBEEF, "single_wr");
      read_burst(12'h100, 8'd0, 3'b010, c_INCR, "single_rd");
      check("single_rdata", rd[0], 32'hDEADBEEF);
      check("single_rlast", 32'(rl[0]), 32'd1);
      check("single_rresp", 32'(rr[0]), 32'd0);

      // INCR burst
      set_beats(3);
      for (int i = 0; i < 4; i++) wd[i] = 32'h11111111 * (i + 1);
      write_burst(12'h200, 8'd3, 3'b010, c_INCR, 2'b00, "incr_wr");
      read_burst(12'h200, 8'd3, 3'b010, c_INCR, "incr_rd");
      for (int i = 0; i < 4; i++) begin
         check("incr_rdata", rd[i], 32'h11111111 * (i + 1));
         check("incr_rlast", 32'(rl[i]), 32'(i == 3));
      end

      // Byte strobes
      wr1(12'h300, 32'hFFFFFFFF, "strb_wr0");
      set_beats(0);
      wd[0] = 32'h00AB0000; ws[0] = 4'b0100;
      write_burst(12'h300, 8'd0, 3'b010, c_INCR, 2'b00, "strb_wr1");
      read_burst(12'h300, 8'd0, 3'b010, c_INCR, "strb_rd");
      check("strb_rdata", rd[0], 32'hFFABFFFF);

      // FIXED burst keeps the last beat
      set_beats(2);
      wd[0] = 32'hAAAA0001; wd[1] = 32'hBBBB0002; wd[2] = 32'hCCCC0003;
      write_burst(12'h304, 8'd2, 3'b010, c_FIXED, 2'b00, "fixed_wr");
      read_burst(12'h304, 8'd0, 3'b010, c_INCR, "fixed_rd");
      check("fixed_rdata", rd[0], 32'hCCCC0003);

      // WRAP write rejected, memory unchanged; WRAP read returns zeros + SLVERR
      wr1(12'h400, 32'h12345678, "wrap_pre");
      set_beats(1);
      wd[0] = 32'hBAD0BAD0; wd[1] = 32'hBAD1BAD1;
      write_burst(12'h400, 8'd1, 3'b010, c_WRAP, 2'b10, "wrap_wr");
      read_burst(12'h400, 8'd0, 3'b010, c_INCR, "wrap_chk");
      check("wrap_mem_kept", rd[0], 32'h12345678);
      read_burst(12'h400, 8'd1, 3'b010, c_WRAP, "wrap_rd");
      for (int i = 0; i < 2; i++) begin
         check("wrap_rd_data", rd[i], 32'd0);
         check("wrap_rd_resp", 32'(rr[i]), 32'd2);
         check("wrap_rd_last", 32'(rl[i]), 32'(i == 1));
      end

      // Early wlast: SLVERR but all beats written
      set_beats(2);
      for (int i = 0; i < 3; i++) wd[i] = 32'h55550000 + i;
      wl[0] = 1'b0; wl[1] = 1'b1; wl[2] = 1'b1;
      write_burst(12'h500, 8'd2, 3'b010, c_INCR, 2'b10, "wlast_wr");
      read_burst(12'h500, 8'd2, 3'b010, c_INCR, "wlast_rd");
      for (int i = 0; i < 3; i++) check("wlast_rdata", rd[i], 32'h55550000 + i);

      // Bad awsize
      wr1(12'h600, 32'h66666666, "size_pre");
      set_beats(0);
      wd[0] = 32'h99999999;
      write_burst(12'h600, 8'd0, 3'b001, c_INCR, 2'b10, "size_wr");
      read_burst(12'h600, 8'd0, 3'b010, c_INCR, "size_rd");
      check("size_mem_kept", rd[0], 32'h66666666);

      // Address wrap-around and read backpressure
      bp_exp[0] = 32'hF0000FF8; bp_exp[1] = 32'hF0000FFC;
      bp_exp[2] = 32'hF0000000; bp_exp[3] = 32'hF0000004;
      set_beats(3);
      for (int i = 0; i < 4; i++) wd[i] = bp_exp[i];
      write_burst(12'hFF8, 8'd3, 3'b010, c_INCR, 2'b00, "bp_wr");
      begin
         int beat = 0;
         int c = 0;
         araddr = 12'hFF8; arlen = 8'd3; arsize = 3'b010; arburst = c_INCR; arvalid = 1'b1;
         check("bp_arready", 32'(arready), 32'd1);
         tick();
         arvalid = 1'b0;
         while (beat < 4 && c < 40) begin
            check("bp_rvalid", 32'(rvalid), 32'd1);
            check("bp_rdata", rdata, bp_exp[beat]);
            check("bp_rlast", 32'(rlast), 32'(beat == 3));
            rready = ((c % 3) == 0);
            if (rready) beat++;
            tick();
            c++;
         end
         rready = 1'b0;
         check("bp_done", 32'(beat), 32'd4);
         check("bp_rvalid_end", 32'(rvalid), 32'd0);
      end

      // B-channel backpressure
      aw_req(12'h700, 8'd0, 3'b010, c_INCR);
      w_send(32'h77777777, 4'hF, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("bhold_bvalid", 32'(bvalid), 32'd1);
         check("bhold_awready", 32'(awready), 32'd0);
         tick();
      end
      b_take(2'b00, "bhold");

      // Same-edge write and read of one word: read sees old data
      aw_req(12'h100, 8'd0, 3'b010, c_INCR);
      check("coll_wready", 32'(wready), 32'd1);
      check("coll_arready", 32'(arready), 32'd1);
      wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
      araddr = 12'h100; arlen = 8'd0; arsize = 3'b010; arburst = c_INCR; arvalid = 1'b1;
      tick();
      wvalid = 1'b0; arvalid = 1'b0;
      check("coll_rvalid", 32'(rvalid), 32'd1);
      check("coll_rdata_old", rdata, 32'hDEADBEEF);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      b_take(2'b00, "coll");
      read_burst(12'h100, 8'd0, 3'b010, c_INCR, "coll_rd");
      check("coll_rdata_new", rd[0], 32'hCAFEF00D);

      // Reset in the middle of a write burst
      for (int i = 0; i < 8; i++) wd[i] = 32'h80000000 + i;
      aw_req(12'h800, 8'd7, 3'b010, c_INCR);
      w_send(wd[0], 4'hF, 1'b0);
      w_send(wd[1], 4'hF, 1'b0);
      reset_rtl_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      tick();
      tick();
      reset_rtl_n = 1'b1;
      tick();
      check("midrst_awready", 32'(awready), 32'd1);
      check("midrst_bvalid", 32'(bvalid), 32'd0);
      wr1(12'h100, 32'h5A5A5A5A, "post_wr");
      read_burst(12'h100, 8'd0, 3'b010, c_INCR, "post_rd");
      check("post_rdata", rd[0], 32'h5A5A5A5A);
      read_burst(12'h800, 8'd1, 3'b010, c_INCR, "abort_rd");
      check("abort_beat0", rd[0], 32'h80000000);
      check("abort_beat1", rd[1], 32'h80000001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi4_sram_responder.md
# axi4_sram_responder

AXI4 slave responder with an internal word-addressed SRAM: accepts write and read bursts from an AXI4 initiator, applies byte-strobed writes, and returns read data with RLAST and OKAY/SLVERR responses. It is the responder end of the S_AXI ports the LSTM accelerator's masters and testbenches drive. It serves as the weight and activation scratchpad behind the interconnect, and as a self-contained RTL target for initiator testbenches.

## Interface
- ADDR_WIDTH, 12, byte address width; memory holds 2^(ADDR_WIDTH-2) 32-bit words.
- DATA_WIDTH, 32, fixed data width; other values are unsupported.
- sys_clock  in  1  single clock; all logic is on its rising edge.
- reset_rtl_n  in  1  asynchronous active-low reset.
- S_AXI_awaddr / awlen / awsize / awburst  in  ADDR_WIDTH/8/3/2  write address channel.
- S_AXI_awvalid  in  1 ; S_AXI_awready  out  1.
- S_AXI_wdata / wstrb / wlast  in  32/4/1 ; S_AXI_wvalid  in  1 ; S_AXI_wready  out  1.
- S_AXI_bresp  out  2 ; S_AXI_bvalid  out  1 ; S_AXI_bready  in  1.
- S_AXI_araddr / arlen / arsize / arburst  in  ADDR_WIDTH/8/3/2 ; S_AXI_arvalid  in  1 ; S_AXI_arready  out  1.
- S_AXI_rdata  out  32 ; S_AXI_rresp  out  2 ; S_AXI_rlast / rvalid  out  1 ; S_AXI_rready  in  1.

## Operation
- The write FSM and read FSM are independent. The memory has one write port and one asynchronous read port.
- **Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.**
  - W_IDLE: awready=1. On awvalid, capture addr[ADDR_WIDTH-1:2], len, burst and size; set beat count to 0; go to W_DATA.
  - W_DATA: wready=1. On each wvalid&&wready beat, write byte i when wstrb[i]=1.
  - INCR advances the word address by 1, wrapping modulo the memory depth. FIXED keeps the address constant.
  - On the beat where count==len, go to W_RESP.
  - wlast is checked but does not end the burst. If wlast!=(count==len) on any beat, the error flag is set; data is still written.
  - W_RESP: bvalid=1 until bready. bresp=2'b10 if the error flag is set, otherwise 2'b00. Then return to W_IDLE.
- **Write errors.** awburst=WRAP or 2'b11, or awsize!=3'b010: the burst is still consumed in full (len+1 beats), writes are suppressed, and bresp=SLVERR.
- **Read FSM: R_IDLE -> R_DATA -> R_IDLE.**
  - R_IDLE: arready=1. On arvalid, capture fields, register rdata=mem[addr], set rvalid=1 and rlast=(arlen==0).
  - R_DATA: rvalid, rdata, rresp and rlast are held stable while rready=0.
  - On rvalid&&rready with rlast=0: advance the address (INCR/FIXED as for writes), load the next word, and keep rvalid=1. This gives one beat per cycle.
  - On the rlast beat: go to R_IDLE with rvalid=0.
- **Read errors.** Bad burst or size: len+1 beats are returned with rdata=0 and rresp=SLVERR.
- **Same-cycle collision.** A write and a read to the same word on the same edge: the read returns the old data (read-before-write).
- Memory contents are not reset.

## Timing
- **Reset values:** awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rlast=0, rresp=0, rdata=0.
- awready and arready rise at the first edge after reset deasserts.
- The ready/valid outputs are registered, state-decoded and Moore-style.
- **Write timing:**
  - AW handshake at edge N gives wready=1 from N.
  - The first beat can complete at N+1.
  - A last beat at edge M gives bvalid=1 from M.
  - After B handshake at edge K, awready=1 from K.
- **Read timing:**
  - AR handshake at edge N gives rvalid=1 and valid rdata from N (one-cycle latency after arvalid is sampled).
  - For a burst of L+1 beats with rready held at 1: rlast is high on the beat at N+L.
  - arready returns after the rlast handshake.
- **Reset mid-burst:** all FSMs go to IDLE immediately. Any partially written burst leaves its already-written beats in memory. No B or R response is issued for the aborted burst.

## Test plan
- **Single write/read.**
  - Write 0x100 <- 0xDEADBEEF, len 0, INCR. Required: bresp=00 one cycle after the W beat.
  - Read 0x100. Required: rdata=0xDEADBEEF, rlast=1, rresp=00, one cycle after the AR handshake.
- **INCR burst.**
  - Write 0x200, len 3, data 0x11111111..0x44444444.
  - Read back with len 3. Required: four consecutive beats in order, rlast only on beat 4.
- **Strobes and FIXED.**
  - Write 0x300 <- 0xFFFFFFFF, then 0x300 <- 0x00AB0000 with wstrb=0100. Required: reading 0x300 gives 0xFFABFFFF.
  - FIXED len 2 write of A, B, C to 0x304. Required: reading 0x304 gives C.
- **Errors.**
  - WRAP burst write to 0x400. Required: bresp=10 and memory unchanged.
  - Early wlast on beat 1 of a len-2 burst. Required: bresp=10, all 3 beats written.
  - awsize=001. Required: SLVERR.
- **Backpressure and wrap-around.**
  - Read 0xFF8, len 3, INCR, with rready toggling 1,0,0,1,... Required: data stable while stalled; addresses returned are 0xFF8, 0xFFC, 0x000, 0x004.
  - Hold bready=0 for 5 cycles. Required: bvalid held and awready=0.
- **Reset mid-burst.**
  - Assert reset_rtl_n=0 after beat 2 of a len-7 write. Required: outputs at reset values immediately.
  - After release, a fresh single write/read at 0x100 passes, and beats 0-1 of the aborted burst are present in memory.
